// File: rtl/param_sp_ram_clr.sv
// Parametrised single-port synchronous RAM with per-byte write enables,
// a one-cycle read-valid pulse and a reset-triggered clear sweep.
module param_sp_ram_clr #(
   parameter int                 DATA_W     = 8,
   parameter int                 ADDR_W     = 2,
   parameter bit                 INIT_CLEAR = 1'b1,
   parameter logic [DATA_W-1:0]  CLR_VAL    = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     din,
   input  logic [DATA_W/8-1:0]   be,
   output logic [DATA_W-1:0]     dout,
   output logic                  rvalid,
   output logic                  busy
);

   localparam int DEPTH  = 2**ADDR_W;
   localparam int NBYTES = DATA_W/8;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   clr_ptr;

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [NBYTES-1:0]   wr_be;
   logic                rd_en;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Expand per-byte enables into a per-bit mask.
   function automatic logic [DATA_W-1:0] expand_be(input logic [NBYTES-1:0] b);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < NBYTES; i++) begin
         m[i*8 +: 8] = {8{b[i]}};
      end
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NBYTES-1:0] b);
      logic [DATA_W-1:0] m;
      m = expand_be(b);
      return (old_w & ~m) | (new_w & m);
   endfunction

   // Next-state and access decode; reset suppresses every memory access.
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_addr   = addr;
      wr_data   = din;
      wr_be     = be;
      rd_en     = 1'b0;
      case (state)
         CLEAR: begin
            wr_en   = !rst;
            wr_addr = clr_ptr;
            wr_data = CLR_VAL;
            wr_be   = '1;
            if (clr_ptr == LAST_ADDR) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            wr_en = !rst && req && we;
            rd_en = !rst && req && !we;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= INIT_CLEAR ? CLEAR : IDLE;
         busy    <= INIT_CLEAR;
         clr_ptr <= '0;
         rvalid  <= 1'b0;
         dout    <= '0;
      end else begin
         state  <= state_nxt;
         busy   <= (state_nxt == CLEAR);
         rvalid <= rd_en;
         if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
         end
         if (rd_en) begin
            dout <= mem[addr];
         end
      end
   end

   // Storage array carries no reset; the sweep gives it defined contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= merge_bytes(mem[wr_addr], wr_data, wr_be);
      end
   end

endmodule

// File: tb/tb_param_sp_ram_clr.sv
// Bench for param_sp_ram_clr: a 32-bit instance checked every cycle against a
// behavioural model, plus two small 8-bit instances for clear-value and no-clear cases.
module tb_param_sp_ram_clr;

   localparam int          A_DW    = 32;
   localparam int          A_AW    = 3;
   localparam int          A_DEPTH = 8;
   localparam logic [31:0] A_CLR   = 32'h5A5A_0F0F;

   logic clk;
   int   checks = 0;
   int   errors = 0;

   // Instance A: 32-bit, 8 words, clear sweep enabled
   logic             a_rst, a_req, a_we;
   logic [A_AW-1:0]  a_addr;
   logic [A_DW-1:0]  a_din;
   logic [3:0]       a_be;
   logic [A_DW-1:0]  a_dout;
   logic             a_rvalid, a_busy;

   // Instance B: 8-bit, 4 words, no clear
   logic        b_rst, b_req, b_we;
   logic [1:0]  b_addr;
   logic [7:0]  b_din;
   logic [0:0]  b_be;
   logic [7:0]  b_dout;
   logic        b_rvalid, b_busy;

   // Instance C: 8-bit, 4 words, clear to 0xFF
   logic        c_rst, c_req, c_we;
   logic [1:0]  c_addr;
   logic [7:0]  c_din;
   logic [0:0]  c_be;
   logic [7:0]  c_dout;
   logic        c_rvalid, c_busy;

   param_sp_ram_clr #(.DATA_W(A_DW), .ADDR_W(A_AW), .INIT_CLEAR(1'b1), .CLR_VAL(A_CLR)) dut_a (
      .clk(clk), .rst(a_rst), .req(a_req), .we(a_we), .addr(a_addr), .din(a_din),
      .be(a_be), .dout(a_dout), .rvalid(a_rvalid), .busy(a_busy));

   param_sp_ram_clr #(.DATA_W(8), .ADDR_W(2), .INIT_CLEAR(1'b0), .CLR_VAL(8'h00)) dut_b (
      .clk(clk), .rst(b_rst), .req(b_req), .we(b_we), .addr(b_addr), .din(b_din),
      .be(b_be), .dout(b_dout), .rvalid(b_rvalid), .busy(b_busy));

   param_sp_ram_clr #(.DATA_W(8), .ADDR_W(2), .INIT_CLEAR(1'b1), .CLR_VAL(8'hFF)) dut_c (
      .clk(clk), .rst(c_rst), .req(c_req), .we(c_we), .addr(c_addr), .din(c_din),
      .be(c_be), .dout(c_dout), .rvalid(c_rvalid), .busy(c_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model for instance A: a plain array, a count of words still to clear,
   // and the last read result.
   logic [31:0] m_mem [A_DEPTH];
   int          m_left = 0;
   logic [31:0] m_dout = '0;
   logic        m_rv = 1'b0;
   bit          m_en = 1'b0;

   always @(posedge clk) begin
      if (a_rst) begin
         m_dout = '0;
         m_rv   = 1'b0;
         m_left = A_DEPTH;
         m_en   = 1'b1;
      end else if (m_left > 0) begin
         m_mem[A_DEPTH - m_left] = A_CLR;
         m_left = m_left - 1;
         m_rv   = 1'b0;
      end else if (a_req && a_we) begin
         for (int b = 0; b < 4; b++) begin
            if (a_be[b]) m_mem[a_addr][b*8 +: 8] = a_din[b*8 +: 8];
         end
         m_rv = 1'b0;
      end else if (a_req) begin
         m_dout = m_mem[a_addr];
         m_rv   = 1'b1;
      end else begin
         m_rv = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_en) begin
         chk("a_busy", a_busy, m_left > 0);
         chk("a_rvalid", a_rvalid, m_rv);
         chk("a_dout", a_dout, m_dout);
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic a_set(input logic req, input logic we, input logic [2:0] ad,
                        input logic [31:0] d, input logic [3:0] b);
      a_req = req; a_we = we; a_addr = ad; a_din = d; a_be = b;
   endtask

   // Count cycles until busy falls, bounded.
   task automatic a_sweep(input string name, input int exp_len);
      int n;
      n = 0;
      while (a_busy && n < 50) begin
         a_set(1'b1, 1'b1, 3'($urandom), $urandom, 4'hF);
         cyc();
         n++;
      end
      chk(name, n, exp_len);
      a_set(1'b0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      int n;
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      a_set(1'b0, 1'b0, '0, '0, '0);
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0; b_be = '0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_din = '0; c_be = '0;
      cyc();
      chk("a_reset_busy", a_busy, 1'b1);
      chk("a_reset_rvalid", a_rvalid, 1'b0);
      chk("a_reset_dout", a_dout, 32'h0);

      // Full sweep with writes attempted throughout
      a_rst = 1'b0;
      a_sweep("a_sweep_len", A_DEPTH);

      // Reset at sweep cycle 4 restarts the sweep
      a_rst = 1'b1; cyc();
      a_rst = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      a_rst = 1'b1; cyc();
      a_rst = 1'b0;
      a_sweep("a_restart_len", A_DEPTH);

      // Byte-enable merge
      a_set(1'b1, 1'b1, 3'd5, 32'hDEAD_BEEF, 4'b1111); cyc();
      a_set(1'b1, 1'b1, 3'd5, 32'h1122_3344, 4'b0101); cyc();
      a_set(1'b1, 1'b0, 3'd5, '0, '0); cyc();
      chk("a_merge_dout", a_dout, 32'hDE22_BE44);
      chk("a_merge_rvalid", a_rvalid, 1'b1);

      // Write then read next cycle, then three back-to-back reads
      a_set(1'b1, 1'b1, 3'd3, 32'h0000_00A5, 4'hF); cyc();
      a_set(1'b1, 1'b0, 3'd3, '0, '0); cyc();
      chk("a_wr_rd_dout", a_dout, 32'h0000_00A5);
      chk("a_wr_rd_rvalid", a_rvalid, 1'b1);
      for (int i = 0; i < 3; i++) begin
         a_set(1'b1, 1'b0, 3'(i), '0, '0); cyc();
         chk("a_b2b_rvalid", a_rvalid, 1'b1);
      end
      chk("a_b2b_last", a_dout, A_CLR);

      // Idle hold after a read
      a_set(1'b1, 1'b1, 3'd6, 32'h0000_003C, 4'hF); cyc();
      a_set(1'b1, 1'b0, 3'd6, '0, '0); cyc();
      a_set(1'b0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("a_hold_rvalid", a_rvalid, 1'b0);
         chk("a_hold_dout", a_dout, 32'h0000_003C);
      end

      // Reset on a read cycle discards the read
      a_set(1'b1, 1'b0, 3'd6, '0, '0);
      a_rst = 1'b1; cyc();
      chk("a_rst_rd_rvalid", a_rvalid, 1'b0);
      chk("a_rst_rd_dout", a_dout, 32'h0);
      a_rst = 1'b0;
      a_sweep("a_sweep_len2", A_DEPTH);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         a_rst = ($urandom_range(0, 63) == 0);
         a_set($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               3'($urandom), $urandom, 4'($urandom));
         cyc();
      end
      a_rst = 1'b0;
      a_set(1'b0, 1'b0, '0, '0, '0);
      n = 0;
      while (a_busy && n < 50) begin cyc(); n++; end
      chk("a_final_idle", a_busy, 1'b0);

      // Instance B: no sweep, usable right after reset
      b_rst = 1'b0;
      chk("b_reset_busy", b_busy, 1'b0);
      b_req = 1'b1; b_we = 1'b1; b_addr = 2'd2; b_din = 8'h77; b_be = 1'b1; cyc();
      chk("b_busy", b_busy, 1'b0);
      chk("b_wr_rvalid", b_rvalid, 1'b0);
      b_we = 1'b0; cyc();
      chk("b_rd_dout", b_dout, 8'h77);
      chk("b_rd_rvalid", b_rvalid, 1'b1);
      b_req = 1'b0; cyc();
      chk("b_idle_rvalid", b_rvalid, 1'b0);

      // Instance C: writes ignored while clearing, all words read 0xFF after
      c_rst = 1'b0;
      n = 0;
      while (c_busy && n < 50) begin
         c_req = 1'b1; c_we = 1'b1; c_addr = 2'(n); c_din = 8'h00; c_be = 1'b1;
         cyc();
         n++;
      end
      chk("c_sweep_len", n, 4);
      for (int i = 0; i < 4; i++) begin
         c_req = 1'b1; c_we = 1'b0; c_addr = 2'(i); cyc();
         chk("c_clr_dout", c_dout, 8'hFF);
         chk("c_clr_rvalid", c_rvalid, 1'b1);
      end
      c_req = 1'b0; cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
